// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter for a single-ported word-access data memory.
// Pipeline: grant (T) -> access stage drives memory (T+1) -> response pulse (T+2).
module dmem_arbiter #(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic        mem_ce,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  logic        last;
  logic        gnt0;
  logic        gnt1;
  logic        gnt_any;

  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [32:0] sel_end;
  logic        sel_err;

  logic        stg_vld;
  logic        stg_port;
  logic        stg_we;
  logic [31:0] stg_addr;
  logic [31:0] stg_wdata;
  logic        stg_err;

  logic        rsp_vld;
  logic        rsp_port;
  logic        rsp_err;
  logic [31:0] rsp_data;

  logic [1:0]  rvalid_v;
  logic [1:0]  err_v;
  logic [31:0] rdata_v [2];

  // On a tie the port that did not win last time is served.
  assign gnt0    = !rst && m0_req && (!m1_req || last);
  assign gnt1    = !rst && m1_req && (!m0_req || !last);
  assign gnt_any = gnt0 || gnt1;
  assign m0_gnt  = gnt0;
  assign m1_gnt  = gnt1;

  assign sel_we    = gnt1 ? m1_we    : m0_we;
  assign sel_addr  = gnt1 ? m1_addr  : m0_addr;
  assign sel_wdata = gnt1 ? m1_wdata : m0_wdata;
  // 33-bit sum so addresses near 2^32 cannot wrap into the legal range.
  assign sel_end   = {1'b0, sel_addr} + 33'd3;
  assign sel_err   = !(sel_end < 33'(MEM_BYTES));

  always_ff @(posedge clk) begin
    if (rst) begin
      last      <= 1'b1;
      stg_vld   <= 1'b0;
      stg_port  <= 1'b0;
      stg_we    <= 1'b0;
      stg_addr  <= '0;
      stg_wdata <= '0;
      stg_err   <= 1'b0;
    end else begin
      stg_vld <= gnt_any;
      if (gnt_any) begin
        last      <= gnt1;
        stg_port  <= gnt1;
        stg_we    <= sel_we;
        stg_addr  <= sel_addr;
        stg_wdata <= sel_wdata;
        stg_err   <= sel_err;
      end
    end
  end

  // Gating with rst drops a write that is in flight when reset arrives.
  assign mem_ce    = stg_vld && !stg_err && !rst;
  assign mem_we    = mem_ce && stg_we;
  assign mem_addr  = stg_addr;
  assign mem_wdata = stg_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_vld  <= 1'b0;
      rsp_port <= 1'b0;
      rsp_err  <= 1'b0;
      rsp_data <= '0;
    end else begin
      rsp_vld <= stg_vld;
      if (stg_vld) begin
        rsp_port <= stg_port;
        rsp_err  <= stg_err;
        rsp_data <= (!stg_err && !stg_we) ? mem_rdata : 32'd0;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      assign rvalid_v[gi] = rsp_vld && (rsp_port == 1'(gi));
      assign err_v[gi]    = rvalid_v[gi] && rsp_err;
      assign rdata_v[gi]  = rvalid_v[gi] ? rsp_data : 32'd0;
    end
  endgenerate

  assign m0_rvalid = rvalid_v[0];
  assign m1_rvalid = rvalid_v[1];
  assign m0_err    = err_v[0];
  assign m1_err    = err_v[1];
  assign m0_rdata  = rdata_v[0];
  assign m1_rdata  = rdata_v[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed scoreboard bench for dmem_arbiter with a simple word memory model.
module tb_dmem_arbiter;

  typedef struct {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    logic        exp_err;
  } port_t;

  typedef struct {
    logic        port;
    logic        err;
    logic [31:0] data;
    int          cyc;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_req = 1'b0, m0_we = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0;
  logic        m1_req = 1'b0, m1_we = 1'b0;
  logic [31:0] m1_addr = '0, m1_wdata = '0;
  logic        m0_gnt, m0_rvalid, m0_err;
  logic [31:0] m0_rdata;
  logic        m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m1_rdata;
  logic        mem_ce, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [256];
  rsp_t        q[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  dmem_arbiter #(.MEM_BYTES(1024)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Word memory: word i initialised to 0xA0000000 | i.
  initial for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 | i;
  always @(posedge clk) if (mem_ce && mem_we) mem[mem_addr[9:2]] <= mem_wdata;
  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: pops one expected response per rvalid pulse.
  always @(negedge clk) begin
    if (m0_rvalid === 1'b1 || m1_rvalid === 1'b1) begin
      if (q.size() == 0) begin
        check("unexpected_rvalid", {62'd0, m1_rvalid, m0_rvalid}, 64'd0);
      end else begin
        rsp_t e;
        e = q.pop_front();
        if (e.port == 1'b0) begin
          check("rsp_port0", {m1_rvalid, m1_err, m1_rdata, m0_rvalid}, {1'b0, 1'b0, 32'd0, 1'b1});
          check("rsp_data0", {31'd0, m0_err, m0_rdata}, {31'd0, e.err, e.data});
        end else begin
          check("rsp_port1", {m0_rvalid, m0_err, m0_rdata, m1_rvalid}, {1'b0, 1'b0, 32'd0, 1'b1});
          check("rsp_data1", {31'd0, m1_err, m1_rdata}, {31'd0, e.err, e.data});
        end
        check("rsp_latency", 64'(cyc), 64'(e.cyc));
        $display("rsp port=%0d err=%0d data=%h cyc=%0d", e.port, e.err, e.data, cyc);
      end
    end
  end

  function automatic port_t mk(input logic req, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] exp_data,
                               input logic exp_err);
    port_t p;
    p.req = req; p.we = we; p.addr = addr; p.wdata = wdata;
    p.exp_data = exp_data; p.exp_err = exp_err;
    return p;
  endfunction

  // One clock cycle: drive, then check grant and memory strobes at the falling edge.
  task automatic tick(input logic rst_v, input port_t p0, input port_t p1,
                      input logic [1:0] exp_gnt, input logic exp_ce, input logic exp_we,
                      input bit push);
    rsp_t e;
    @(posedge clk);
    #1;
    rst = rst_v;
    m0_req = p0.req; m0_we = p0.we; m0_addr = p0.addr; m0_wdata = p0.wdata;
    m1_req = p1.req; m1_we = p1.we; m1_addr = p1.addr; m1_wdata = p1.wdata;
    @(negedge clk);
    check("gnt", {62'd0, m1_gnt, m0_gnt}, {62'd0, exp_gnt});
    check("mem_ce_we", {62'd0, mem_ce, mem_we}, {62'd0, exp_ce, exp_we});
    $display("cyc=%0d rst=%0d gnt=%b%b ce=%0d we=%0d", cyc, rst, m1_gnt, m0_gnt, mem_ce, mem_we);
    if (push && exp_gnt != 2'b00) begin
      e.port = exp_gnt[1];
      e.err  = exp_gnt[1] ? p1.exp_err : p0.exp_err;
      e.data = exp_gnt[1] ? p1.exp_data : p0.exp_data;
      e.cyc  = cyc + 2;
      q.push_back(e);
    end
  endtask

  initial begin
    port_t idle, r0, r1;
    idle = mk(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
    r0   = mk(1'b1, 1'b0, 32'h40, 32'd0, 32'hA000_0010, 1'b0);
    r1   = mk(1'b1, 1'b0, 32'h80, 32'd0, 32'hA000_0020, 1'b0);
    rst = 1'b1;
    m0_req = 1'b1; m1_req = 1'b1;

    // Reset held two cycles with both ports requesting.
    tick(1'b1, r0, r1, 2'b00, 1'b0, 1'b0, 1'b1);
    tick(1'b1, r0, r1, 2'b00, 1'b0, 1'b0, 1'b1);

    // Contention straight after release: first tie goes to port 0.
    tick(1'b0, r0, r1, 2'b01, 1'b0, 1'b0, 1'b1);
    check("post_reset_outputs", {30'd0, m0_rvalid, m1_rvalid, m0_rdata | m1_rdata},
          {30'd0, 2'b00, 32'd0});
    check("post_reset_err", {62'd0, m0_err, m1_err}, 64'd0);
    tick(1'b0, r0, r1, 2'b10, 1'b1, 1'b0, 1'b1);
    tick(1'b0, r0, r1, 2'b01, 1'b1, 1'b0, 1'b1);
    tick(1'b0, r0, r1, 2'b10, 1'b1, 1'b0, 1'b1);
    tick(1'b0, r0, r1, 2'b01, 1'b1, 1'b0, 1'b1);
    tick(1'b0, r0, r1, 2'b10, 1'b1, 1'b0, 1'b1);
    tick(1'b0, idle, idle, 2'b00, 1'b1, 1'b0, 1'b1);
    tick(1'b0, idle, idle, 2'b00, 1'b0, 1'b0, 1'b1);

    // Port 0 write followed immediately by read of the same word.
    tick(1'b0, mk(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 32'd0, 1'b0), idle, 2'b01, 1'b0, 1'b0, 1'b1);
    tick(1'b0, mk(1'b1, 1'b0, 32'h10, 32'd0, 32'hDEAD_BEEF, 1'b0), idle, 2'b01, 1'b1, 1'b1, 1'b1);
    tick(1'b0, idle, idle, 2'b00, 1'b1, 1'b0, 1'b1);
    tick(1'b0, idle, idle, 2'b00, 1'b0, 1'b0, 1'b1);

    // Out of range 0x3FD, then the last legal word 0x3FC.
    tick(1'b0, idle, mk(1'b1, 1'b0, 32'h3FD, 32'd0, 32'd0, 1'b1), 2'b10, 1'b0, 1'b0, 1'b1);
    tick(1'b0, idle, mk(1'b1, 1'b0, 32'h3FC, 32'd0, 32'hA000_00FF, 1'b0), 2'b10, 1'b0, 1'b0, 1'b1);
    tick(1'b0, idle, mk(1'b1, 1'b0, 32'hFFFF_FFFD, 32'd0, 32'd0, 1'b1), 2'b10, 1'b1, 1'b0, 1'b1);
    tick(1'b0, idle, idle, 2'b00, 1'b0, 1'b0, 1'b1);
    tick(1'b0, idle, idle, 2'b00, 1'b0, 1'b0, 1'b1);

    // Reset arrives while a port 1 write sits in the access stage.
    tick(1'b0, idle, mk(1'b1, 1'b1, 32'h20, 32'h1234_5678, 32'd0, 1'b0), 2'b10, 1'b0, 1'b0, 1'b0);
    tick(1'b1, idle, idle, 2'b00, 1'b0, 1'b0, 1'b0);
    tick(1'b0, idle, idle, 2'b00, 1'b0, 1'b0, 1'b1);
    tick(1'b0, idle, mk(1'b1, 1'b0, 32'h20, 32'd0, 32'hA000_0008, 1'b0), 2'b10, 1'b0, 1'b0, 1'b1);
    tick(1'b0, idle, idle, 2'b00, 1'b1, 1'b0, 1'b1);
    tick(1'b0, idle, idle, 2'b00, 1'b0, 1'b0, 1'b1);

    // Lone requester on port 1: four back-to-back reads.
    for (int i = 0; i < 4; i++)
      tick(1'b0, idle, mk(1'b1, 1'b0, 32'h100 + 32'(4 * i), 32'd0, 32'hA000_0040 + 32'(i), 1'b0),
           2'b10, (i != 0), 1'b0, 1'b1);
    tick(1'b0, idle, idle, 2'b00, 1'b1, 1'b0, 1'b1);
    tick(1'b0, idle, idle, 2'b00, 1'b0, 1'b0, 1'b1);
    tick(1'b0, idle, idle, 2'b00, 1'b0, 1'b0, 1'b1);

    check("queue_drained", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
